// File: rtl/hilo_mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hilo_mdu_ctrl_pkg
//   Shared definitions for the EX-stage multiply/divide controller:
//     - legacy DATALENGTH / ZeroWord macros used across the core
//     - md_op_e     : EX-stage mul/div/move-to-HI/LO operation encoding
//     - md_state_e  : controller FSM state encoding
//     - md_is_long  : true for operations that occupy the MDU for several cycles
// -----------------------------------------------------------------------------
`ifndef DATALENGTH
`define DATALENGTH 32
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package hilo_mdu_ctrl_pkg;

    localparam int MD_DATA_W_DEF = `DATALENGTH;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    // Multiplies and divides hold the pipeline; moves to HI/LO do not.
    function automatic logic md_is_long(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// hilo_mdu_ctrl_if
//   Handshake bundle between the HI/LO controller and the radix-2 divider.
//     div_start_o  : start request, held high until the result is taken
//     div_annul_o  : abort the operation in flight (EX flush)
//     div_signed_o : 1 = signed divide
//     div_op1_o    : dividend
//     div_op2_o    : divisor
//     div_hi_i     : remainder
//     div_lo_i     : quotient
//     div_busy_i   : divider busy; low while start is high means result valid
//   master = controller side, slave = divider side.
// -----------------------------------------------------------------------------
interface hilo_mdu_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              div_start_o;
    logic              div_annul_o;
    logic              div_signed_o;
    logic [DATA_W-1:0] div_op1_o;
    logic [DATA_W-1:0] div_op2_o;
    logic [DATA_W-1:0] div_hi_i;
    logic [DATA_W-1:0] div_lo_i;
    logic              div_busy_i;

    modport master (
        output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        input  div_hi_i, div_lo_i, div_busy_i
    );

    modport slave (
        input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        output div_hi_i, div_lo_i, div_busy_i
    );
endinterface

// File: rtl/hilo_mdu_ctrl_mdu_mul.sv
// -----------------------------------------------------------------------------
// mdu_mul
//   MUL_CYCLES-stage (DATA_W+1)x(DATA_W+1) signed multiplier. Operands are
//   captured on ld_i and extended by one bit (sign or zero according to
//   sgn_i), so one signed multiplier serves both MULT and MULTU. The product
//   is valid MUL_CYCLES-1 clocks after the first cycle following capture,
//   i.e. in the last MUL-state cycle of the controller.
//   Ports:
//     clk     clock
//     ld_i    capture a_i/b_i/sgn_i this edge
//     sgn_i   1 = sign-extend operands, 0 = zero-extend
//     a_i,b_i raw DATA_W operands
//     prod_o  low 2*DATA_W bits of the product (the full MIPS HI:LO result)
//   Pure datapath: no reset, the controller's counter qualifies prod_o.
// -----------------------------------------------------------------------------
module mdu_mul #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  ld_i,
    input  logic                  sgn_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic [2*DATA_W-1:0]   prod_o
);

    logic signed [DATA_W:0]   opa_p0;
    logic signed [DATA_W:0]   opb_p0;
    logic [2*DATA_W-1:0]      prod_p1;

    // Product of two DATA_W+1 operands, truncated to 2*DATA_W bits. Extending
    // both operands to 2*DATA_W first keeps every bit of the low half exact
    // without carrying the two redundant top bits around.
    function automatic logic [2*DATA_W-1:0] mul_trunc(
        input logic signed [DATA_W:0] a,
        input logic signed [DATA_W:0] b
    );
        logic signed [2*DATA_W-1:0] a_x;
        logic signed [2*DATA_W-1:0] b_x;
        a_x = {{(DATA_W-1){a[DATA_W]}}, a};
        b_x = {{(DATA_W-1){b[DATA_W]}}, b};
        return a_x * b_x;
    endfunction

    // ---- stage p0: operand capture at issue ----
    always_ff @(posedge clk) begin
        if (ld_i) begin
            opa_p0 <= {sgn_i & a_i[DATA_W-1], a_i};
            opb_p0 <= {sgn_i & b_i[DATA_W-1], b_i};
        end
    end

    // ---- stage p1: multiply ----
    assign prod_p1 = mul_trunc(opa_p0, opb_p0);

    generate
        if (MUL_CYCLES <= 1) begin : g_single
            assign prod_o = prod_p1;
        end else begin : g_pipe
            logic [MUL_CYCLES-2:0][2*DATA_W-1:0] prod_q;

            // ---- stages p2..: product pipeline ----
            always_ff @(posedge clk) begin
                prod_q[0] <= prod_p1;
                for (int k = 1; k < MUL_CYCLES - 1; k++) begin
                    prod_q[k] <= prod_q[k-1];
                end
            end

            assign prod_o = prod_q[MUL_CYCLES-2];
        end
    endgenerate

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_mdu_ctrl
//   EX-stage multiply/divide controller and owner of the HI/LO registers.
//   Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the internal mdu_mul,
//   sequences the external divider and stalls EX until the result lands in
//   HI/LO.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     valid_i    EX instruction valid
//     op_i       md_op_e operation
//     rs_i,rt_i  operands (sampled only at issue)
//     flush_i    EX flush; aborts everything, no HI/LO write
//     stall_o    hold EX and earlier stages
//     hi_o,lo_o  architectural HI/LO
//     div_bus    divider handshake (master side)
// -----------------------------------------------------------------------------
module hilo_mdu_ctrl
    import hilo_mdu_ctrl_pkg::*;
#(
    parameter int DATA_W     = MD_DATA_W_DEF,
    parameter int MUL_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   rs_i,
    input  logic [DATA_W-1:0]   rt_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    hilo_mdu_ctrl_if.master     div_bus
);

    localparam int              CNT_W    = 2;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                div_start_q, div_start_d;
    logic                div_signed_q, div_signed_d;
    logic [DATA_W-1:0]   div_op1_q, div_op1_d;
    logic [DATA_W-1:0]   div_op2_q, div_op2_d;
    logic                stall;
    logic                mul_ld;
    logic                mul_sgn;
    logic [2*DATA_W-1:0] mul_prod;
    md_op_e              op;

    assign op = md_op_e'(op_i);

    mdu_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk    (clk),
        .ld_i   (mul_ld),
        .sgn_i  (mul_sgn),
        .a_i    (rs_i),
        .b_i    (rt_i),
        .prod_o (mul_prod)
    );

    // ---- FSM next state, HI/LO and divider handshake ----
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        div_start_d  = div_start_q;
        div_signed_d = div_signed_q;
        div_op1_d    = div_op1_q;
        div_op2_d    = div_op2_q;
        stall        = 1'b0;
        mul_ld       = 1'b0;
        mul_sgn      = 1'b0;

        if (flush_i) begin
            // Flush wins even over a completing result: nothing is written.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            div_start_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        stall = md_is_long(op);
                        unique case (op)
                            MD_MULT, MD_MULTU: begin
                                mul_ld  = 1'b1;
                                mul_sgn = (op == MD_MULT);
                                cnt_d   = '0;
                                state_d = ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                div_op1_d    = rs_i;
                                div_op2_d    = rt_i;
                                div_signed_d = (op == MD_DIV);
                                div_start_d  = 1'b1;
                                state_d      = ST_DIV_WAIT;
                            end
                            MD_MTHI: hi_d = rs_i;
                            MD_MTLO: lo_d = rs_i;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    stall = 1'b1;
                    if (cnt_q == MUL_LAST) begin
                        {hi_d, lo_d} = mul_prod;
                        cnt_d        = '0;
                        state_d      = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DIV_WAIT: begin
                    stall = 1'b1;
                    if (!div_bus.div_busy_i) begin
                        hi_d        = div_bus.div_hi_i;
                        lo_d        = div_bus.div_lo_i;
                        div_start_d = 1'b0;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Same instruction still sits in EX this cycle; let it go.
                    div_start_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            div_start_q  <= 1'b0;
            div_signed_q <= 1'b0;
            div_op1_q    <= '0;
            div_op2_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            div_start_q  <= div_start_d;
            div_signed_q <= div_signed_d;
            div_op1_q    <= div_op1_d;
            div_op2_q    <= div_op2_d;
        end
    end

    assign stall_o              = stall;
    assign hi_o                 = hi_q;
    assign lo_o                 = lo_q;
    assign div_bus.div_start_o  = div_start_q;
    assign div_bus.div_annul_o  = flush_i;
    assign div_bus.div_signed_o = div_signed_q;
    assign div_bus.div_op1_o    = div_op1_q;
    assign div_bus.div_op2_o    = div_op2_q;

endmodule
